// File: rtl/fetch_pc_gen_pkg.sv
// Shared front-end definitions for the stage-0 fetch PC generator.
package fetch_pc_gen_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h1C00_0000;
    localparam int          FETCH_GROUP_BYTES = 16;
    // log2(FETCH_GROUP_BYTES): byte-offset bits inside one fetch group
    localparam int          GROUP_OFFSET_W    = 4;
    localparam int          SLOT_W            = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage1_reg.sv
// Stage-1 fetch-group register: flush invalidates, hold freezes, otherwise capture.
module fetch_stage1_reg
    import fetch_pc_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_en,
    input  logic              hold,
    input  logic              group_vld,
    input  logic [31:0]       group_pc,
    input  logic [SLOT_W-1:0] group_mask,
    input  logic              btb_hit,
    input  logic [31:0]       btb_target,
    output logic [31:0]       pc_s1,
    output logic              vld_s1,
    output logic [SLOT_W-1:0] mask_s1,
    output logic              taken_s1,
    output logic [31:0]       target_s1
);

    logic taken;

    // A prediction only counts when the group itself is a real fetch
    assign taken = group_vld & btb_hit;

    // Flush has priority over hold; on flush only the valid bit changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_s1     <= '0;
            vld_s1    <= 1'b0;
            mask_s1   <= '0;
            taken_s1  <= 1'b0;
            target_s1 <= '0;
        end else if (flush_en) begin
            vld_s1    <= 1'b0;
        end else if (!hold) begin
            pc_s1     <= group_pc;
            vld_s1    <= group_vld;
            mask_s1   <= group_vld ? group_mask : '0;
            taken_s1  <= taken;
            target_s1 <= taken ? btb_target : '0;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Stage-0 fetch PC generator: owns the fetch PC and fetch-request FSM.
//
//   state | meaning
//   BOOT  | first cycle after reset, no request issued
//   RUN   | issuing one fetch group per cycle
//   HALT  | IDLE executed; waits for a backend redirect
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_en,
    input  logic [31:0]       flush_PC,
    input  logic              fetch_stop,
    input  logic              hold_stage1_2,
    input  logic              BTB_hit,
    input  logic [31:0]       PC_target,
    input  logic [SLOT_W-1:0] inst_vld_stage0,
    output logic [31:0]       PC,
    output logic              PC_vld,
    output logic [31:0]       PC_stage1,
    output logic              vld_stage1,
    output logic [SLOT_W-1:0] inst_vld_stage1,
    output logic              pred_taken_stage1,
    output logic [31:0]       pred_target_stage1
);

    localparam logic [31-GROUP_OFFSET_W:0] GROUP_INC = 1;

    fetch_state_t                state_q, state_d;
    logic [31:0]                 pc_q, pc_d;
    logic [31-GROUP_OFFSET_W:0]  group_next;
    logic                        advance;
    logic [1:0]                  unused_flush_lsb;

    // Redirect targets are word aligned; the low bits are dropped
    assign unused_flush_lsb = flush_PC[1:0];

    assign PC         = pc_q;
    assign PC_vld     = (state_q == ST_RUN);
    assign group_next = pc_q[31:GROUP_OFFSET_W] + GROUP_INC;
    // PC moves on its own only while running, not stalled and not stopping
    assign advance    = PC_vld & ~hold_stage1_2 & ~fetch_stop;

    // State and fetch PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state: redirect always resumes fetching, IDLE parks the FSM
    always_comb begin
        state_d = state_q;
        if (flush_en) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  state_d = fetch_stop ? ST_HALT : ST_RUN;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    // Next PC: redirect, then hold/idle, then prediction, then fall-through
    always_comb begin
        pc_d = pc_q;
        if (flush_en) begin
            pc_d = {flush_PC[31:2], 2'b00};
        end else if (advance) begin
            if (BTB_hit) begin
                pc_d = PC_target;
            end else begin
                pc_d = {group_next, {GROUP_OFFSET_W{1'b0}}};
            end
        end
    end

    fetch_stage1_reg u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_en   (flush_en),
        .hold       (hold_stage1_2),
        .group_vld  (PC_vld),
        .group_pc   (pc_q),
        .group_mask (inst_vld_stage0),
        .btb_hit    (BTB_hit),
        .btb_target (PC_target),
        .pc_s1      (PC_stage1),
        .vld_s1     (vld_stage1),
        .mask_s1    (inst_vld_stage1),
        .taken_s1   (pred_taken_stage1),
        .target_s1  (pred_target_stage1)
    );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus a randomized
// run against a behavioural model of the fetch front end.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_en;
    logic [31:0] flush_PC;
    logic        fetch_stop;
    logic        hold_stage1_2;
    logic        BTB_hit;
    logic [31:0] PC_target;
    logic [3:0]  inst_vld_stage0;
    logic [31:0] PC;
    logic        PC_vld;
    logic [31:0] PC_stage1;
    logic        vld_stage1;
    logic [3:0]  inst_vld_stage1;
    logic        pred_taken_stage1;
    logic [31:0] pred_target_stage1;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halt;
    logic [31:0] m_s1pc;
    bit          m_s1vld;
    logic [3:0]  m_s1mask;
    bit          m_s1tk;
    logic [31:0] m_s1tgt;

    always #5 clk = ~clk;

    fetch_pc_gen #(.RESET_PC(32'h1C00_0000)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush_en           (flush_en),
        .flush_PC           (flush_PC),
        .fetch_stop         (fetch_stop),
        .hold_stage1_2      (hold_stage1_2),
        .BTB_hit            (BTB_hit),
        .PC_target          (PC_target),
        .inst_vld_stage0    (inst_vld_stage0),
        .PC                 (PC),
        .PC_vld             (PC_vld),
        .PC_stage1          (PC_stage1),
        .vld_stage1         (vld_stage1),
        .inst_vld_stage1    (inst_vld_stage1),
        .pred_taken_stage1  (pred_taken_stage1),
        .pred_target_stage1 (pred_target_stage1)
    );

    function automatic bit m_vld();
        return !m_boot && !m_halt;
    endfunction

    task automatic model_reset();
        m_pc = 32'h1C00_0000; m_boot = 1; m_halt = 0;
        m_s1pc = 0; m_s1vld = 0; m_s1mask = 0; m_s1tk = 0; m_s1tgt = 0;
    endtask

    task automatic idle_inputs();
        flush_en = 0; flush_PC = 0; fetch_stop = 0; hold_stage1_2 = 0;
        BTB_hit = 0; PC_target = 0; inst_vld_stage0 = 4'hF;
    endtask

    // One clock: advance the model from the inputs the DUT will sample, then step.
    task automatic tick();
        bit          v;
        logic [31:0] npc;
        bit          nh;
        v   = m_vld();
        npc = m_pc;
        nh  = m_halt;
        if (flush_en) begin
            npc = flush_PC & 32'hFFFF_FFFC;
            nh  = 0;
        end else begin
            if (v && !hold_stage1_2 && !fetch_stop)
                npc = BTB_hit ? PC_target : (m_pc & 32'hFFFF_FFF0) + 32'd16;
            if (v && fetch_stop) nh = 1;
        end
        @(posedge clk);
        if (flush_en) begin
            m_s1vld = 0;
        end else if (!hold_stage1_2) begin
            m_s1pc   = m_pc;
            m_s1vld  = v;
            m_s1mask = v ? inst_vld_stage0 : 4'h0;
            m_s1tk   = v && BTB_hit;
            m_s1tgt  = m_s1tk ? PC_target : 32'h0;
        end
        m_pc   = npc;
        m_halt = nh;
        m_boot = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        model_reset();
        #2;
        checks++; if (PC !== 32'h1C00_0000) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 32'h1C00_0000); end
        checks++; if (PC_vld !== 1'b0) begin errors++; $display("FAIL reset_pc_vld: got %b want 0", PC_vld); end
        checks++; if ({PC_stage1, vld_stage1, inst_vld_stage1, pred_taken_stage1, pred_target_stage1} !== 70'h0)
            begin errors++; $display("FAIL reset_stage1: got %h/%b/%b/%b/%h want zeros", PC_stage1, vld_stage1, inst_vld_stage1, pred_taken_stage1, pred_target_stage1); end
        @(negedge clk) rst_n = 1;
        #1;
        checks++; if (PC_vld !== 1'b0 || PC !== 32'h1C00_0000) begin errors++; $display("FAIL boot_cycle: got %h/%b want 1c000000/0", PC, PC_vld); end
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (PC !== 32'h1C00_0000 || PC_vld !== 1'b1) begin errors++; $display("FAIL seq_first: got %h/%b want 1c000000/1", PC, PC_vld); end
        checks++; if (vld_stage1 !== 1'b0) begin errors++; $display("FAIL seq_s1_boot: got %b want 0", vld_stage1); end
        tick();
        checks++; if (PC !== 32'h1C00_0010) begin errors++; $display("FAIL seq_second: got %h want 1c000010", PC); end
        checks++; if (PC_stage1 !== 32'h1C00_0000 || vld_stage1 !== 1'b1) begin errors++; $display("FAIL seq_s1_lag: got %h/%b want 1c000000/1", PC_stage1, vld_stage1); end
        tick();
        checks++; if (PC !== 32'h1C00_0020 || PC_stage1 !== 32'h1C00_0010) begin errors++; $display("FAIL seq_third: got %h/%h want 1c000020/1c000010", PC, PC_stage1); end
    endtask

    task automatic test_btb_taken();
        flush_en = 1; flush_PC = 32'h1C00_0024;
        tick();
        flush_en = 0;
        checks++; if (PC !== 32'h1C00_0024 || PC_vld !== 1'b1 || vld_stage1 !== 1'b0) begin errors++; $display("FAIL btb_setup: got %h/%b/%b want 1c000024/1/0", PC, PC_vld, vld_stage1); end
        BTB_hit = 1; PC_target = 32'h1C00_0100; inst_vld_stage0 = 4'b0110;
        tick();
        BTB_hit = 0; inst_vld_stage0 = 4'hF;
        checks++; if (PC !== 32'h1C00_0100) begin errors++; $display("FAIL btb_next_pc: got %h want 1c000100", PC); end
        checks++; if (PC_stage1 !== 32'h1C00_0024 || inst_vld_stage1 !== 4'b0110 || pred_taken_stage1 !== 1'b1 || pred_target_stage1 !== 32'h1C00_0100)
            begin errors++; $display("FAIL btb_stage1: got %h/%b/%b/%h want 1c000024/0110/1/1c000100", PC_stage1, inst_vld_stage1, pred_taken_stage1, pred_target_stage1); end
        tick();
        checks++; if (PC !== 32'h1C00_0110 || pred_taken_stage1 !== 1'b0 || pred_target_stage1 !== 32'h0)
            begin errors++; $display("FAIL btb_not_taken: got %h/%b/%h want 1c000110/0/0", PC, pred_taken_stage1, pred_target_stage1); end
    endtask

    task automatic test_hold();
        flush_en = 1; flush_PC = 32'h1C00_0030;
        tick();
        flush_en = 0;
        tick();
        hold_stage1_2 = 1; BTB_hit = 1; PC_target = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PC !== 32'h1C00_0040 || PC_stage1 !== 32'h1C00_0030 || vld_stage1 !== 1'b1 || pred_taken_stage1 !== 1'b0 || inst_vld_stage1 !== 4'hF)
                begin errors++; $display("FAIL hold_freeze[%0d]: got %h/%h/%b/%b/%b want 1c000040/1c000030/1/0/1111", i, PC, PC_stage1, vld_stage1, pred_taken_stage1, inst_vld_stage1); end
        end
        hold_stage1_2 = 0; BTB_hit = 0;
        tick();
        checks++; if (PC !== 32'h1C00_0050 || PC_stage1 !== 32'h1C00_0040) begin errors++; $display("FAIL hold_resume: got %h/%h want 1c000050/1c000040", PC, PC_stage1); end
    endtask

    task automatic test_flush_during_hold();
        hold_stage1_2 = 1; flush_en = 1; flush_PC = 32'h8000_0007;
        tick();
        flush_en = 0;
        checks++; if (PC !== 32'h8000_0004 || PC_vld !== 1'b1 || vld_stage1 !== 1'b0) begin errors++; $display("FAIL flush_hold: got %h/%b/%b want 80000004/1/0", PC, PC_vld, vld_stage1); end
        tick();
        checks++; if (PC !== 32'h8000_0004 || vld_stage1 !== 1'b0) begin errors++; $display("FAIL flush_then_hold: got %h/%b want 80000004/0", PC, vld_stage1); end
        hold_stage1_2 = 0;
    endtask

    task automatic test_fetch_stop();
        fetch_stop = 1;
        tick();
        fetch_stop = 0;
        checks++; if (PC_vld !== 1'b0 || PC !== 32'h8000_0004) begin errors++; $display("FAIL stop_enter: got %h/%b want 80000004/0", PC, PC_vld); end
        checks++; if (PC_stage1 !== 32'h8000_0004 || vld_stage1 !== 1'b1) begin errors++; $display("FAIL stop_capture: got %h/%b want 80000004/1", PC_stage1, vld_stage1); end
        for (int i = 0; i < 10; i++) begin
            BTB_hit = 1'($urandom); PC_target = $urandom;
            tick();
            checks++; if (PC_vld !== 1'b0 || PC !== 32'h8000_0004 || vld_stage1 !== 1'b0 || pred_taken_stage1 !== 1'b0)
                begin errors++; $display("FAIL halt_hold[%0d]: got %h/%b/%b/%b want 80000004/0/0/0", i, PC, PC_vld, vld_stage1, pred_taken_stage1); end
        end
        BTB_hit = 0;
        flush_en = 1; flush_PC = 32'h1C00_0200;
        tick();
        flush_en = 0;
        checks++; if (PC !== 32'h1C00_0200 || PC_vld !== 1'b1) begin errors++; $display("FAIL halt_exit: got %h/%b want 1c000200/1", PC, PC_vld); end
    endtask

    task automatic test_wrap();
        flush_en = 1; flush_PC = 32'hFFFF_FFF8;
        tick();
        flush_en = 0;
        tick();
        checks++; if (PC !== 32'h0000_0000 || PC_vld !== 1'b1) begin errors++; $display("FAIL wrap: got %h/%b want 00000000/1", PC, PC_vld); end
        tick();
        checks++; if (PC !== 32'h0000_0010 || PC_stage1 !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h/%h want 00000010/00000000", PC, PC_stage1); end
    endtask

    task automatic test_async_reset();
        BTB_hit = 1; PC_target = 32'h1234_5678;
        tick();
        tick();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++; if (PC !== 32'h1C00_0000 || PC_vld !== 1'b0) begin errors++; $display("FAIL async_rst_pc: got %h/%b want 1c000000/0", PC, PC_vld); end
        checks++; if ({PC_stage1, vld_stage1, inst_vld_stage1, pred_taken_stage1, pred_target_stage1} !== 70'h0)
            begin errors++; $display("FAIL async_rst_s1: got %h/%b/%b/%b/%h want zeros", PC_stage1, vld_stage1, inst_vld_stage1, pred_taken_stage1, pred_target_stage1); end
        idle_inputs();
        @(negedge clk) rst_n = 1;
        tick();
        checks++; if (PC_vld !== 1'b1 || PC !== 32'h1C00_0000) begin errors++; $display("FAIL async_rst_restart: got %h/%b want 1c000000/1", PC, PC_vld); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            flush_en        = ($urandom_range(0, 19) == 0);
            flush_PC        = $urandom;
            fetch_stop      = ($urandom_range(0, 29) == 0);
            hold_stage1_2   = ($urandom_range(0, 4) == 0);
            BTB_hit         = ($urandom_range(0, 3) == 0);
            PC_target       = $urandom;
            inst_vld_stage0 = 4'($urandom);
            tick();
            checks++; if (PC !== m_pc || PC_vld !== m_vld())
                begin errors++; $display("FAIL rnd_pc[%0d]: got %h/%b want %h/%b", i, PC, PC_vld, m_pc, m_vld()); end
            checks++; if (PC_stage1 !== m_s1pc || vld_stage1 !== m_s1vld || inst_vld_stage1 !== m_s1mask)
                begin errors++; $display("FAIL rnd_s1[%0d]: got %h/%b/%b want %h/%b/%b", i, PC_stage1, vld_stage1, inst_vld_stage1, m_s1pc, m_s1vld, m_s1mask); end
            checks++; if (pred_taken_stage1 !== m_s1tk || pred_target_stage1 !== m_s1tgt)
                begin errors++; $display("FAIL rnd_pred[%0d]: got %b/%h want %b/%h", i, pred_taken_stage1, pred_target_stage1, m_s1tk, m_s1tgt); end
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_btb_taken();
        test_hold();
        test_flush_during_hold();
        test_fetch_stop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
